// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU: field positions, opcodes, FSM states
// and the immediate sign-extension helper.
package cpu_pkg;

  localparam int XLEN    = 32;
  localparam int OP_LSB  = 28;
  localparam int OP_W    = 4;
  localparam int RD_LSB  = 25;
  localparam int RS1_LSB = 22;
  localparam int RS2_LSB = 19;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 16;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_ADDI = 4'd6,
    OP_LUI  = 4'd7,
    OP_LW   = 4'd8,
    OP_SW   = 4'd9,
    OP_BEQ  = 4'd10,
    OP_BNE  = 4'd11,
    OP_JAL  = 4'd12,
    OP_HALT = 4'd15
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_EXEC   = 3'd1,
    S_LOAD   = 3'd2,
    S_STORE  = 3'd3,
    S_HALTED = 3'd4
  } state_e;

  function automatic logic [XLEN-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// General register file: two combinational read ports, one synchronous write port,
// entry 0 reads as zero and ignores writes.
module cpu_regfile
  import cpu_pkg::*;
#(
  parameter int NREGS = 8,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [AW-1:0]   raddr1_i,
  output logic [XLEN-1:0] rdata1_o,
  input  logic [AW-1:0]   raddr2_i,
  output logic [XLEN-1:0] rdata2_o
);

  logic [XLEN-1:0] regs_q [NREGS];

  // register storage with asynchronous clear
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= {XLEN{1'b0}};
      end
    end else if (we_i && (waddr_i != {AW{1'b0}})) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == {AW{1'b0}}) ? {XLEN{1'b0}} : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == {AW{1'b0}}) ? {XLEN{1'b0}} : regs_q[raddr2_i];

endmodule

// File: rtl/cpu_top.sv
// Multi-cycle CPU core: FETCH/EXEC/LOAD/STORE/HALTED FSM, PC, instruction register
// and ALU; all memory-port outputs come straight from flops.
module cpu_top
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 8
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        instr_req,
  output logic [31:0] instr_addr,
  input  logic        instr_valid,
  input  logic [31:0] instr_rdata,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  input  logic        rd_valid,
  input  logic [31:0] rd_rdata,
  output logic        wr_req,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  input  logic        wr_ack,
  output logic [31:0] pc,
  output logic        halted
);

  localparam int AW = $clog2(NREGS);
  localparam logic [XLEN-1:0] WORD_MASK = 32'hFFFF_FFFC;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, ir_q, ir_d;
  logic [XLEN-1:0] instr_addr_q, instr_addr_d, rd_addr_q, rd_addr_d;
  logic [XLEN-1:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic            instr_req_q, instr_req_d, rd_req_q, rd_req_d;
  logic            wr_req_q, wr_req_d, halted_q, halted_d;

  logic [3:0]      opcode_s;
  logic [AW-1:0]   rd_s, rs1_s, rs2_s;
  logic [XLEN-1:0] rs1_val_s, rs2_val_s, imm_s, alu_s, ea_s, pc_plus4_s, br_target_s;
  logic            rf_we_s;
  logic [XLEN-1:0] rf_wdata_s;
  logic            unused_s;

  assign opcode_s    = ir_q[OP_LSB +: OP_W];
  assign rd_s        = ir_q[RD_LSB +: AW];
  assign rs1_s       = ir_q[RS1_LSB +: AW];
  assign rs2_s       = ir_q[RS2_LSB +: AW];
  assign imm_s       = sext_imm(ir_q[IMM_LSB +: IMM_W]);
  assign ea_s        = (rs1_val_s + imm_s) & WORD_MASK;
  assign pc_plus4_s  = pc_q + 32'd4;
  assign br_target_s = pc_plus4_s + (imm_s << 2);
  assign unused_s    = ^ir_q[18:16];

  cpu_regfile #(.NREGS(NREGS)) u_regfile (
    .clk_i    (clk),
    .rst_i    (rstn),
    .we_i     (rf_we_s),
    .waddr_i  (rd_s),
    .wdata_i  (rf_wdata_s),
    .raddr1_i (rs1_s),
    .rdata1_o (rs1_val_s),
    .raddr2_i (rs2_s),
    .rdata2_o (rs2_val_s)
  );

  // ALU result for register-writing arithmetic/logic opcodes
  always_comb begin
    alu_s = {XLEN{1'b0}};
    case (opcode_s)
      OP_ADD:  alu_s = rs1_val_s + rs2_val_s;
      OP_SUB:  alu_s = rs1_val_s - rs2_val_s;
      OP_AND:  alu_s = rs1_val_s & rs2_val_s;
      OP_OR:   alu_s = rs1_val_s | rs2_val_s;
      OP_XOR:  alu_s = rs1_val_s ^ rs2_val_s;
      OP_ADDI: alu_s = rs1_val_s + imm_s;
      OP_LUI:  alu_s = {ir_q[IMM_LSB +: IMM_W], 16'h0000};
      default: alu_s = {XLEN{1'b0}};
    endcase
  end

  // next-state, PC, register write-back and port-register values
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rf_we_s    = 1'b0;
    rf_wdata_s = alu_s;
    case (state_q)
      S_FETCH: begin
        if (instr_req_q && instr_valid) begin
          ir_d    = instr_rdata;
          state_d = S_EXEC;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_plus4_s;
        case (opcode_s)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI, OP_LUI: rf_we_s = 1'b1;
          OP_LW: begin
            rd_addr_d = ea_s;
            pc_d      = pc_q;
            state_d   = S_LOAD;
          end
          OP_SW: begin
            wr_addr_d = ea_s;
            wr_data_d = rs2_val_s;
            pc_d      = pc_q;
            state_d   = S_STORE;
          end
          OP_BEQ:  pc_d = (rs1_val_s == rs2_val_s) ? br_target_s : pc_plus4_s;
          OP_BNE:  pc_d = (rs1_val_s != rs2_val_s) ? br_target_s : pc_plus4_s;
          OP_JAL: begin
            rf_we_s    = 1'b1;
            rf_wdata_s = pc_plus4_s;
            pc_d       = br_target_s;
          end
          OP_HALT: begin
            pc_d    = pc_q;
            state_d = S_HALTED;
          end
          default: pc_d = pc_plus4_s;
        endcase
      end
      S_LOAD: begin
        if (rd_req_q && rd_valid) begin
          rf_we_s    = 1'b1;
          rf_wdata_s = rd_rdata;
          pc_d       = pc_plus4_s;
          state_d    = S_FETCH;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_STORE: begin
        if (wr_req_q && wr_ack) begin
          pc_d    = pc_plus4_s;
          state_d = S_FETCH;
        end else begin
          state_d = S_STORE;
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_FETCH;
    endcase
    // requests follow the state being entered so they rise together with it
    instr_req_d  = (state_d == S_FETCH);
    rd_req_d     = (state_d == S_LOAD);
    wr_req_d     = (state_d == S_STORE);
    halted_d     = (state_d == S_HALTED);
    instr_addr_d = (state_d == S_FETCH) ? pc_d : instr_addr_q;
  end

  // state, PC, instruction and port registers
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      ir_q         <= {XLEN{1'b0}};
      instr_req_q  <= 1'b0;
      instr_addr_q <= {XLEN{1'b0}};
      rd_req_q     <= 1'b0;
      rd_addr_q    <= {XLEN{1'b0}};
      wr_req_q     <= 1'b0;
      wr_addr_q    <= {XLEN{1'b0}};
      wr_data_q    <= {XLEN{1'b0}};
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      instr_req_q  <= instr_req_d;
      instr_addr_q <= instr_addr_d;
      rd_req_q     <= rd_req_d;
      rd_addr_q    <= rd_addr_d;
      wr_req_q     <= wr_req_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      halted_q     <= halted_d;
    end
  end

  assign instr_req  = instr_req_q;
  assign instr_addr = instr_addr_q;
  assign rd_req     = rd_req_q;
  assign rd_addr    = rd_addr_q;
  assign wr_req     = wr_req_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign pc         = pc_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_cpu_top.sv
// Self-checking bench for cpu_top: directed program, reset during a store, and
// random programs compared against an instruction-level reference model.
module tb_cpu_top;

  logic        clk = 1'b0;
  logic        rstn;
  logic        instr_req, instr_valid, rd_req, rd_valid, wr_req, wr_ack, halted;
  logic [31:0] instr_addr, instr_rdata, rd_addr, rd_rdata, wr_addr, wr_data, pc;

  always #5 clk = ~clk;

  cpu_top #(.RESET_PC(32'h0000_0000), .NREGS(8)) dut (
    .clk(clk), .rstn(rstn),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_valid(instr_valid), .instr_rdata(instr_rdata),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_rdata(rd_rdata),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .pc(pc), .halted(halted)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] imem [256];
  bit   [31:0] dmem [bit [31:0]];
  int          iw_cfg = 0, rw_cfg = 0, ww_cfg = 0;   // wait cycles per port, -1 = random 0..2
  int          patch_n = -1;
  logic [31:0] patch_addr = 32'h0, patch_word = 32'h0;
  logic [31:0] ilog[$], slog_a[$], slog_d[$];
  int          slog_c[$], rlog_c[$];
  logic [31:0] exp_f[$], exp_sa[$], exp_sd[$];

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] enc(input int op, input int rd, input int rs1, input int rs2,
                                      input logic [15:0] imm);
    return {op[3:0], rd[2:0], rs1[2:0], rs2[2:0], 3'b000, imm};
  endfunction

  function automatic int pick(input int cfg);
    return (cfg < 0) ? int'($urandom_range(0, 2)) : cfg;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: drives valid/ack on the falling edge after the chosen wait
  initial begin
    int icnt, rcnt, wcnt, iwait, rwait, wwait;
    logic [31:0] wa0, wd0;
    icnt = 0; rcnt = 0; wcnt = 0; iwait = 0; rwait = 0; wwait = 0;
    wa0 = 32'h0; wd0 = 32'h0;
    instr_valid = 1'b0; instr_rdata = 32'h0; rd_valid = 1'b0; rd_rdata = 32'h0; wr_ack = 1'b0;
    forever begin
      @(negedge clk);
      check("one_outstanding",
            32'((instr_req & rd_req) | (instr_req & wr_req) | (rd_req & wr_req)), 32'd0);
      if (instr_req) begin
        if (icnt == 0) iwait = pick(iw_cfg);
        if (icnt >= iwait) begin
          instr_valid = 1'b1;
          instr_rdata = (patch_n >= 0 && ilog.size() >= patch_n && instr_addr == patch_addr)
                        ? patch_word : imem[instr_addr[9:2]];
          ilog.push_back(instr_addr);
          icnt = 0;
        end else begin
          instr_valid = 1'b0;
          icnt++;
        end
      end else begin
        instr_valid = 1'b0;
        icnt = 0;
      end
      if (rd_req) begin
        if (rcnt == 0) rwait = pick(rw_cfg);
        if (rcnt >= rwait) begin
          rd_valid = 1'b1;
          rd_rdata = dmem.exists(rd_addr) ? dmem[rd_addr] : mem_init(rd_addr);
          rlog_c.push_back(rcnt + 1);
          rcnt = 0;
        end else begin
          rd_valid = 1'b0;
          rd_rdata = 32'hDEAD_BEEF;
          rcnt++;
        end
      end else begin
        rd_valid = 1'b0;
        rcnt = 0;
      end
      if (wr_req) begin
        if (wcnt == 0) begin
          wwait = pick(ww_cfg);
          wa0 = wr_addr;
          wd0 = wr_data;
        end else begin
          check("wr_addr_stable", wr_addr, wa0);
          check("wr_data_stable", wr_data, wd0);
        end
        if (wcnt >= wwait) begin
          wr_ack = 1'b1;
          dmem[wr_addr] = wr_data;
          slog_a.push_back(wr_addr);
          slog_d.push_back(wr_data);
          slog_c.push_back(wcnt + 1);
          wcnt = 0;
        end else begin
          wr_ack = 1'b0;
          wcnt++;
        end
      end else begin
        wr_ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Instruction-level reference: walks imem from address 0 until HALT
  task automatic run_model();
    logic [31:0] r [8];
    bit   [31:0] m [bit [31:0]];
    logic [31:0] p, w, a, b, se, nxt, val, ad;
    int op, d;
    bit wr;
    exp_f.delete(); exp_sa.delete(); exp_sd.delete();
    for (int i = 0; i < 8; i++) r[i] = 32'h0;
    p = 32'h0;
    for (int s = 0; s < 2000; s++) begin
      w = imem[p[9:2]];
      exp_f.push_back(p);
      op  = int'(w[31:28]);
      d   = int'(w[27:25]);
      a   = r[w[24:22]];
      b   = r[w[21:19]];
      se  = {{16{w[15]}}, w[15:0]};
      nxt = p + 32'd4;
      val = 32'h0;
      wr  = 1'b0;
      ad  = (a + se) & 32'hFFFF_FFFC;
      if (op == 15) break;
      case (op)
        1:  begin val = a + b; wr = 1'b1; end
        2:  begin val = a - b; wr = 1'b1; end
        3:  begin val = a & b; wr = 1'b1; end
        4:  begin val = a | b; wr = 1'b1; end
        5:  begin val = a ^ b; wr = 1'b1; end
        6:  begin val = a + se; wr = 1'b1; end
        7:  begin val = w[15:0] * 32'd65536; wr = 1'b1; end
        8:  begin val = m.exists(ad) ? m[ad] : mem_init(ad); wr = 1'b1; end
        9:  begin m[ad] = b; exp_sa.push_back(ad); exp_sd.push_back(b); end
        10: if (a == b) nxt = nxt + se * 32'd4;
        11: if (a != b) nxt = nxt + se * 32'd4;
        12: begin val = p + 32'd4; wr = 1'b1; nxt = nxt + se * 32'd4; end
        default: ;
      endcase
      if (wr && d != 0) r[d] = val;
      p = nxt;
    end
  endtask

  task automatic clear_logs();
    ilog.delete(); slog_a.delete(); slog_d.delete(); slog_c.delete(); rlog_c.delete();
    dmem.delete();
  endtask

  task automatic wait_fetches(input int n, input int budget);
    int c = 0;
    while (ilog.size() < n && c < budget) begin
      tick();
      c++;
    end
    check("fetch_wait_budget", 32'(ilog.size() >= n), 32'd1);
  endtask

  task automatic wait_halted(input int budget);
    int c = 0;
    while (halted !== 1'b1 && c < budget) begin
      tick();
      c++;
    end
    check("halt_wait_budget", 32'(halted), 32'd1);
  endtask

  task automatic compare_run(input string tag);
    int nf, ns;
    check({tag, "_fetch_count"}, ilog.size(), exp_f.size());
    check({tag, "_store_count"}, slog_a.size(), exp_sa.size());
    nf = (ilog.size() < exp_f.size()) ? ilog.size() : exp_f.size();
    ns = (slog_a.size() < exp_sa.size()) ? slog_a.size() : exp_sa.size();
    for (int i = 0; i < nf; i++) check($sformatf("%s_fetch[%0d]", tag, i), ilog[i], exp_f[i]);
    for (int i = 0; i < ns; i++) begin
      check($sformatf("%s_st_addr[%0d]", tag, i), slog_a[i], exp_sa[i]);
      check($sformatf("%s_st_data[%0d]", tag, i), slog_d[i], exp_sd[i]);
    end
  endtask

  initial begin
    logic [31:0] dir_f [19];
    logic [31:0] dir_sa [5];
    logic [31:0] dir_sd [5];
    dir_f  = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h20,
               32'h24, 32'h28, 32'h2C, 32'h30, 32'h3C, 32'h40, 32'h44, 32'h48, 32'h4C};
    dir_sa = '{32'h10, 32'h20, 32'h24, 32'h28, 32'h2C};
    dir_sd = '{32'h5, 32'h2, 32'hFFFF_FFF8, 32'h5, 32'h34};

    // ---- directed program ----
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    imem[2]  = enc(6, 1, 0, 0, 16'd5);
    imem[3]  = enc(6, 2, 0, 0, 16'hFFFD);
    imem[4]  = enc(1, 3, 1, 2, 16'd0);
    imem[5]  = enc(2, 4, 2, 1, 16'd0);
    imem[6]  = enc(9, 0, 0, 1, 16'h0010);
    imem[7]  = enc(8, 5, 0, 0, 16'h0010);
    imem[8]  = enc(11, 0, 1, 0, 16'hFFFF);
    imem[12] = enc(12, 7, 0, 0, 16'd2);
    imem[13] = enc(6, 6, 0, 0, 16'd1);
    imem[14] = enc(6, 6, 0, 0, 16'd1);
    imem[15] = enc(9, 0, 0, 3, 16'h0020);
    imem[16] = enc(9, 0, 0, 4, 16'h0024);
    imem[17] = enc(9, 0, 0, 5, 16'h0028);
    imem[18] = enc(9, 0, 0, 7, 16'h002C);
    imem[19] = enc(15, 0, 0, 0, 16'd0);
    patch_n = 9; patch_addr = 32'h20; patch_word = enc(10, 0, 1, 0, 16'd5);
    iw_cfg = 0; rw_cfg = 2; ww_cfg = 3;

    rstn = 1'b1;
    clear_logs();
    tick(); tick();
    check("rst_instr_req", 32'(instr_req), 32'd0);
    check("rst_rd_req", 32'(rd_req), 32'd0);
    check("rst_wr_req", 32'(wr_req), 32'd0);
    check("rst_instr_addr", instr_addr, 32'h0);
    check("rst_rd_addr", rd_addr, 32'h0);
    check("rst_wr_addr", wr_addr, 32'h0);
    check("rst_wr_data", wr_data, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_halted", 32'(halted), 32'd0);
    rstn = 1'b0;
    tick();
    check("first_fetch_req", 32'(instr_req), 32'd1);
    check("first_fetch_addr", instr_addr, 32'h0);
    wait_fetches(3, 50);
    check("pc_after_two_nops", pc, 32'h8);
    wait_fetches(19, 600);
    check("halt_not_yet", 32'(halted), 32'd0);
    tick();
    check("halted_next_cycle", 32'(halted), 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("halted_no_req", 32'({instr_req, rd_req, wr_req}), 32'd0);
    end
    check("dir_fetch_count", ilog.size(), 32'd19);
    for (int i = 0; i < 19 && i < ilog.size(); i++)
      check($sformatf("dir_fetch[%0d]", i), ilog[i], dir_f[i]);
    check("dir_store_count", slog_a.size(), 32'd5);
    for (int i = 0; i < 5 && i < slog_a.size(); i++) begin
      check($sformatf("dir_st_addr[%0d]", i), slog_a[i], dir_sa[i]);
      check($sformatf("dir_st_data[%0d]", i), slog_d[i], dir_sd[i]);
    end
    if (slog_c.size() > 0) check("sw_req_cycles", slog_c[0], 32'd4);
    else check("sw_req_seen", 32'd0, 32'd1);
    if (rlog_c.size() > 0) check("lw_req_cycles", rlog_c[0], 32'd3);
    else check("lw_req_seen", 32'd0, 32'd1);

    // ---- reset while a store is waiting for its ack ----
    rstn = 1'b1;
    patch_n = -1;
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    imem[0] = enc(9, 0, 0, 0, 16'h0040);
    imem[1] = enc(15, 0, 0, 0, 16'd0);
    iw_cfg = 0; ww_cfg = 1000;
    tick();
    clear_logs();
    rstn = 1'b0;
    begin
      int c = 0;
      while (wr_req !== 1'b1 && c < 50) begin
        tick();
        c++;
      end
    end
    check("wr_req_before_reset", 32'(wr_req), 32'd1);
    check("wr_addr_before_reset", wr_addr, 32'h40);
    #2;
    rstn = 1'b1;
    #1;
    check("wr_req_cleared_async", 32'(wr_req), 32'd0);
    check("wr_addr_cleared_async", wr_addr, 32'h0);
    check("pc_reset_async", pc, 32'h0);
    tick();

    // ---- random programs against the reference model ----
    iw_cfg = -1; rw_cfg = -1; ww_cfg = -1;
    for (int t = 0; t < 20; t++) begin
      rstn = 1'b1;
      tick();
      clear_logs();
      for (int i = 0; i < 256; i++) imem[i] = 32'h0;
      for (int i = 0; i < 20; i++) begin
        int op;
        logic [15:0] imm;
        op  = int'($urandom_range(0, 14));
        imm = 16'($urandom);
        if (op >= 10 && op <= 12) imm = 16'($urandom_range(0, 19 - i));
        imem[i] = enc(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 7)), imm);
      end
      for (int k = 1; k < 8; k++) imem[19 + k] = enc(9, 0, 0, k, 16'(16'h0100 + 4 * k));
      imem[27] = enc(15, 0, 0, 0, 16'd0);
      run_model();
      rstn = 1'b0;
      wait_halted(3000);
      compare_run($sformatf("rnd%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_top.md
# cpu_top

Multi-cycle 32-bit CPU core that sits beside the memory subsystem on a shared clock/reset bundle.
- Fetches instructions through an instruction read port.
- Performs loads through a data read port and stores through a data write port.
- Executes a small fixed-format ISA until it reaches HALT.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: fetch address after reset.
- NREGS, 8: number of general registers; r0 is hardwired to zero.

Ports:
- clk, in, 1: single clock, rising edge.
- rstn, in, 1: reset, asynchronous, active-high (1 = in reset).
- instr_req, out, 1: instruction fetch request.
- instr_addr, out, 32: fetch address, word aligned.
- instr_valid, in, 1: instruction data valid.
- instr_rdata, in, 32: instruction word.
- rd_req, out, 1: data read request.
- rd_addr, out, 32: read address, word aligned.
- rd_valid, in, 1: read data valid.
- rd_rdata, in, 32: read data.
- wr_req, out, 1: data write request.
- wr_addr, out, 32: write address, word aligned.
- wr_data, out, 32: write data.
- wr_ack, in, 1: write accepted.
- pc, out, 32: current program counter.
- halted, out, 1: core has stopped.

## Operation
Instruction fields:
- [31:28] opcode, [27:25] rd, [24:22] rs1, [21:19] rs2, [15:0] imm. sext(imm) is the 32-bit sign extension of imm.

Opcodes:
- 0 NOP.
- 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: rd = rs1 op rs2.
- 6 ADDI: rd = rs1 + sext(imm).
- 7 LUI: rd = {imm, 16'h0}.
- 8 LW: rd = mem[rs1 + sext(imm)].
- 9 SW: mem[rs1 + sext(imm)] = rs2.
- 10 BEQ / 11 BNE: if the condition holds, pc = pc + 4 + (sext(imm) << 2).
- 12 JAL: rd = pc + 4; pc = pc + 4 + (sext(imm) << 2).
- 15 HALT.
- 13, 14: executed as NOP.

Arithmetic and registers:
- All arithmetic is 32-bit modulo 2^32. Overflow is ignored.
- PC wraps from 32'hFFFF_FFFC to 0.
- Writes to r0 are discarded; reads of r0 return 0.
- Memory addresses have bits [1:0] forced to 0.
- Non-branch instructions set pc = pc + 4.

State machine:
- FETCH: instr_req = 1, instr_addr = pc. Stays in FETCH until instr_valid = 1, then latches instr_rdata → EXEC.
- EXEC: decode and execute ALU/branch/JAL ops, update pc → FETCH. LW → LOAD. SW → STORE. HALT → HALTED.
- LOAD: rd_req = 1 until rd_valid = 1, then writes rd_rdata to rd, pc += 4 → FETCH.
- STORE: wr_req = 1 with stable addr/data until wr_ack = 1, then pc += 4 → FETCH.
- HALTED: halted = 1, all requests 0. Leaves this state only through reset.

## Timing
Reset (rstn = 1):
- All req outputs 0; all addr/data outputs 0.
- pc = RESET_PC, registers 0, halted 0, state FETCH.
- Applies immediately, asynchronously.
- Reset asserted mid-transaction drops the request in the same cycle. Memory must tolerate abandoned requests.
- The first fetch request appears in the first clock cycle after reset deasserts.

Handshakes:
- A request stays high and its address/data stay stable until the matching valid/ack is sampled high.
- Valid/ack may arrive in the same cycle as the request (zero wait) or any later cycle.
- Valid/ack received while no request is pending is ignored.
- At most one request is outstanding at any time. Fetch, read and write are never concurrent.

Latency with zero-wait memory:
- ALU, branch, JAL, NOP: 2 cycles.
- LW, SW: 3 cycles.
- Each wait cycle on a port adds one cycle.

## Structure
- Package cpu_pkg holds:
  - opcode enum;
  - FSM state enum;
  - field bit positions;
  - XLEN = 32.
- One sub-module, cpu_regfile: NREGS × 32, two combinational read ports, one synchronous write port, r0 forced to zero.
- The top module holds the FSM, PC, instruction register and ALU.

## Test plan
- Reset then zero-wait fetch: instr_addr 0, 4, 8 on consecutive fetch cycles; pc = 8 after two NOPs.
- ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2 → r3 = 2. SUB r4,r2,r1 → 32'hFFFF_FFF8.
- SW r1 to [r0+0x10] with a 3-cycle wr_ack delay: wr_req high 4 cycles, wr_addr 0x10, wr_data 5. Then LW r5 gets 5 with rd_valid delayed 2 cycles.
- BNE r1,r0,-1 at pc 0x20 → next fetch at 0x20. BEQ not taken → 0x24. JAL r7,+2 at 0x30 → r7 = 0x34, fetch at 0x3C.
- HALT → halted = 1 the next cycle, no further requests. Reset asserted while wr_req is pending clears wr_req in the same cycle.
